custom_wptr_full: RTL and testbench
===================================

# custom_wptr_full

Write-side pointer and full-flag generator for the asynchronous FIFO. It sits directly downstream of the read-to-write pointer synchronizer and consumes the 2-flop-synchronized Gray read pointer in the `wclk_i` domain. From that pointer and the write requests it produces:
- the binary write address into the dual-port RAM;
- the Gray write pointer sent to the write-to-read synchronizer;
- a registered, conservative full flag, fill level and overflow indication.

## Interface
Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; legal range 2..31
- AFULL_THRESH, 2**ADDRSIZE-2, fill level at or above which walmost_full_o asserts; legal range 1..2**ADDRSIZE

Ports:
- wclk_i  input  1  write-domain clock
- wrst_n_i  input  1  asynchronous active-low reset
- winc_i  input  1  write request from producer
- rptr_sync2_wrclk_i  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk_i
- wen_o  output  1  RAM write strobe, combinational: winc_i & ~wfull_o
- waddr_o  output  ADDRSIZE  RAM write address, equal to wbin[ADDRSIZE-1:0]
- wptr_g_o  output  ADDRSIZE+1  registered Gray write pointer
- wfull_o  output  1  registered full flag
- wlevel_o  output  ADDRSIZE+1  registered conservative fill level, 0..2**ADDRSIZE
- wovf_o  output  1  sticky overflow: a write was attempted while full
- walmost_full_o  output  1  almost-full flag; exists only with the configuration macro defined

Reset is wrst_n_i, asynchronous, active-low, and the clock is wclk_i.

## Operation
- Internal register wbin holds the binary write pointer, ADDRSIZE+1 bits, and wraps modulo 2**(ADDRSIZE+1).
- Next pointer: wbin_nxt = wbin + (winc_i & ~wfull_o).
- Next Gray pointer: wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt.
  - Registered into wptr_g_o every cycle.
  - Consecutive values of wptr_g_o differ in exactly one bit.
- Full test: wfull_nxt = (wgray_nxt == {~rptr[ADDRSIZE:ADDRSIZE-1], rptr[ADDRSIZE-2:0]}), where rptr is rptr_sync2_wrclk_i.
- Level:
  - rbin = Gray-to-binary of rptr_sync2_wrclk_i, computed as a prefix XOR from the MSB down.
  - wlevel_nxt = (wbin_nxt - rbin) mod 2**(ADDRSIZE+1).
- Write while full (winc_i=1, wfull_o=1):
  - the write is dropped: wen_o=0 and the pointer holds;
  - wovf_o sets and stays set until reset.
- No other state. The block is a registered pointer datapath, not a multi-state FSM.

## Timing
- Reset values: wbin=0, wptr_g_o=0, waddr_o=0, wfull_o=0, wlevel_o=0, wovf_o=0, walmost_full_o=0.
- Reset mid-operation clears all state immediately, with no dependency on wclk_i.
- Accepted write at edge N:
  - waddr_o and wptr_g_o advance at edge N;
  - wfull_o and wlevel_o reflect that write at edge N.
- Full asserts at the same edge that registers the write filling the last slot. The producer never sees a stale not-full after its final write.
- Full deasserts no earlier than the edge after rptr_sync2_wrclk_i changes. This is pessimistic by the 2-cycle synchronizer latency plus read-side latency, which is intended.
- Simultaneous write and synchronized read-pointer change in one cycle: both enter the same wlevel_nxt/wfull_nxt computation, so no update is lost.
- Pointer wrap from 2**(ADDRSIZE+1)-1 to 0 is seamless. The MSB inversion in the full test handles lap detection.
- wen_o is combinational from a registered flag. Its only combinational path is winc_i to wen_o.

## Configuration
- Macro WPTR_FULL_AFULL_EN.
- Defined:
  - walmost_full_o port exists;
  - registered as (wlevel_nxt >= AFULL_THRESH);
  - same timing as wfull_o.
- Undefined:
  - port and comparator are absent;
  - all other behaviour is identical.

## Test plan
All scenarios use ADDRSIZE=2 (depth 4) and hold rptr_sync2_wrclk_i=0 unless stated otherwise.
- Reset check: assert wrst_n_i low mid-stream after 3 writes.
  - Required: all outputs return to 0 asynchronously.
  - Required: first write after release uses waddr_o=0.
- Fill: 4 back-to-back writes.
  - Required: waddr_o sequence 0,1,2,3.
  - Required: wptr_g_o sequence 000→001→011→010→110.
  - Required: wfull_o=1 and wlevel_o=4 at the edge of the 4th write.
- Overflow: with the FIFO full, pulse winc_i once.
  - Required: wen_o=0, wptr_g_o stays 110.
  - Required: wovf_o=1 and stays 1 through later writes and reads.
- Drain release: from full, set rptr_sync2_wrclk_i=001.
  - Required: next edge wfull_o=0 and wlevel_o=3.
  - Then one write: wfull_o=1, wptr_g_o=111.
- Wrap: stream 20 writes, each followed by a matching Gray read-pointer advance.
  - Required: wptr_g_o wraps 100→000 with a single-bit change on every step.
  - Required: wfull_o never asserts; wlevel_o stays ≤1.
- Almost-full, with WPTR_FULL_AFULL_EN defined and AFULL_THRESH=3:
  - walmost_full_o=0 at level 2;
  - rises at the edge of the 3rd write;
  - falls at the edge after rptr_sync2_wrclk_i makes the level 2.

Source files
------------

// File: rtl/custom_wptr_full.sv
// custom_wptr_full
//   Write-side pointer and full-flag generator for an asynchronous FIFO.
//   Consumes the read pointer (Gray code, already synchronized into wclk_i).
//   Produces the RAM write strobe and address, the Gray write pointer for
//   the write-to-read synchronizer, and a conservative full flag, fill level
//   and sticky overflow flag.
//
//   Optional feature macro: WPTR_FULL_AFULL_EN
//     When defined, adds walmost_full_o, registered as level >= AFULL_THRESH.
//
// Ports
//   wclk_i             write-domain clock
//   wrst_n_i           asynchronous active-low reset
//   winc_i             write request from the producer
//   rptr_sync2_wrclk_i synchronized Gray read pointer, ADDRSIZE+1 bits
//   wen_o              RAM write strobe (winc_i & ~wfull_o)
//   waddr_o            RAM write address
//   wptr_g_o           registered Gray write pointer
//   wfull_o            registered full flag
//   wlevel_o           registered conservative fill level, 0..2**ADDRSIZE
//   wovf_o             sticky: a write was attempted while full
//   walmost_full_o     registered almost-full flag (WPTR_FULL_AFULL_EN only)
module custom_wptr_full #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = 2**ADDRSIZE - 2
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic                winc_i,
    input  logic [ADDRSIZE:0]   rptr_sync2_wrclk_i,
    output logic                wen_o,
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [ADDRSIZE:0]   wptr_g_o,
    output logic                wfull_o,
    output logic [ADDRSIZE:0]   wlevel_o,
    output logic                wovf_o
`ifdef WPTR_FULL_AFULL_EN
    ,
    output logic                walmost_full_o
`endif
);

    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbin_nxt;
    logic [ADDRSIZE:0] wgray_nxt;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rptr_full_cmp;
    logic [ADDRSIZE:0] wlevel_nxt;
    logic              wfull_nxt;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_rbin
        assign rbin[i] = ^(rptr_sync2_wrclk_i >> i);
    end

    // A write is accepted only when not full; a write while full is dropped.
    assign wen_o     = winc_i & ~wfull_o;
    assign wbin_nxt  = wbin + (ADDRSIZE+1)'(wen_o);
    assign wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt;

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits inverted, the rest equal.
    assign rptr_full_cmp = {~rptr_sync2_wrclk_i[ADDRSIZE:ADDRSIZE-1],
                            rptr_sync2_wrclk_i[ADDRSIZE-2:0]};
    assign wfull_nxt     = (wgray_nxt == rptr_full_cmp);

    // Modular difference; the pointer MSB makes 2**ADDRSIZE representable.
    assign wlevel_nxt = wbin_nxt - rbin;

    assign waddr_o = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wbin     <= '0;
            wptr_g_o <= '0;
            wfull_o  <= 1'b0;
            wlevel_o <= '0;
            wovf_o   <= 1'b0;
        end else begin
            wbin     <= wbin_nxt;
            wptr_g_o <= wgray_nxt;
            wfull_o  <= wfull_nxt;
            wlevel_o <= wlevel_nxt;
            if (winc_i && wfull_o) begin
                wovf_o <= 1'b1;
            end
        end
    end

`ifdef WPTR_FULL_AFULL_EN
    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            walmost_full_o <= 1'b0;
        end else begin
            walmost_full_o <= (wlevel_nxt >= AFULL_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_custom_wptr_full.sv
// tb_custom_wptr_full
//   Directed bench for custom_wptr_full with ADDRSIZE=2 (depth 4) and
//   AFULL_THRESH=3. Expected values are hand-derived constants plus a small
//   binary-to-Gray helper for the wrap stream.
module tb_custom_wptr_full;

    logic       wclk_i;
    logic       wrst_n_i;
    logic       winc_i;
    logic [2:0] rptr_sync2_wrclk_i;
    logic       wen_o;
    logic [1:0] waddr_o;
    logic [2:0] wptr_g_o;
    logic       wfull_o;
    logic [2:0] wlevel_o;
    logic       wovf_o;
`ifdef WPTR_FULL_AFULL_EN
    logic       walmost_full_o;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    custom_wptr_full #(
        .ADDRSIZE     (2),
        .AFULL_THRESH (3)
    ) dut (
        .wclk_i             (wclk_i),
        .wrst_n_i           (wrst_n_i),
        .winc_i             (winc_i),
        .rptr_sync2_wrclk_i (rptr_sync2_wrclk_i),
        .wen_o              (wen_o),
        .waddr_o            (waddr_o),
        .wptr_g_o           (wptr_g_o),
        .wfull_o            (wfull_o),
        .wlevel_o           (wlevel_o),
        .wovf_o             (wovf_o)
`ifdef WPTR_FULL_AFULL_EN
        ,
        .walmost_full_o     (walmost_full_o)
`endif
    );

    initial wclk_i = 1'b0;
    always #5 wclk_i = ~wclk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle 1 time unit past it.
    task automatic step();
        @(posedge wclk_i);
        #1;
    endtask

    function automatic logic [2:0] gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [2:0] bptr;
        logic [2:0] prev_g;
        logic [2:0] diff;
        bit         wrap_seen;

        wrst_n_i = 1'b0;
        winc_i   = 1'b0;
        rptr_sync2_wrclk_i = 3'b000;
        #2;
        chk("rst_g",    8'(wptr_g_o), 8'h0);
        chk("rst_addr", 8'(waddr_o),  8'h0);
        chk("rst_full", 8'(wfull_o),  8'h0);
        chk("rst_lvl",  8'(wlevel_o), 8'h0);
        chk("rst_ovf",  8'(wovf_o),   8'h0);
        step();
        wrst_n_i = 1'b1;
        step();

        // Three writes, then an asynchronous reset between edges.
        winc_i = 1'b1;
        step(); step(); step();
        winc_i = 1'b0;
        chk("pre_rst_addr", 8'(waddr_o),  8'h3);
        chk("pre_rst_g",    8'(wptr_g_o), 8'h2);
        chk("pre_rst_lvl",  8'(wlevel_o), 8'h3);
        #2;
        wrst_n_i = 1'b0;
        #1;
        chk("arst_addr", 8'(waddr_o),  8'h0);
        chk("arst_g",    8'(wptr_g_o), 8'h0);
        chk("arst_lvl",  8'(wlevel_o), 8'h0);
        chk("arst_full", 8'(wfull_o),  8'h0);
        chk("arst_ovf",  8'(wovf_o),   8'h0);
        step();
        wrst_n_i = 1'b1;
        step();

        // Fill: addresses used 0..3, Gray 001,011,010,110.
        winc_i = 1'b1;
        #1;
        chk("fill_wen",   8'(wen_o),    8'h1);
        chk("fill_addr0", 8'(waddr_o),  8'h0);
        step();
        chk("fill_g1",    8'(wptr_g_o), 8'h1);
        chk("fill_addr1", 8'(waddr_o),  8'h1);
        chk("fill_full1", 8'(wfull_o),  8'h0);
        step();
        chk("fill_g2",    8'(wptr_g_o), 8'h3);
        chk("fill_addr2", 8'(waddr_o),  8'h2);
        step();
        chk("fill_g3",    8'(wptr_g_o), 8'h2);
        chk("fill_addr3", 8'(waddr_o),  8'h3);
        chk("fill_full3", 8'(wfull_o),  8'h0);
        step();
        chk("fill_g4",    8'(wptr_g_o), 8'h6);
        chk("fill_full4", 8'(wfull_o),  8'h1);
        chk("fill_lvl4",  8'(wlevel_o), 8'h4);
        chk("fill_ovf4",  8'(wovf_o),   8'h0);

        // Overflow: write attempt while full is dropped and latched.
        #1;
        chk("ovf_wen", 8'(wen_o), 8'h0);
        step();
        winc_i = 1'b0;
        chk("ovf_g",    8'(wptr_g_o), 8'h6);
        chk("ovf_flag", 8'(wovf_o),   8'h1);
        chk("ovf_full", 8'(wfull_o),  8'h1);
        chk("ovf_lvl",  8'(wlevel_o), 8'h4);

        // Drain release: read pointer advances by one.
        rptr_sync2_wrclk_i = 3'b001;
        step();
        chk("drain_full", 8'(wfull_o),  8'h0);
        chk("drain_lvl",  8'(wlevel_o), 8'h3);
        winc_i = 1'b1;
        step();
        winc_i = 1'b0;
        chk("refill_full", 8'(wfull_o),  8'h1);
        chk("refill_g",    8'(wptr_g_o), 8'h7);
        chk("refill_lvl",  8'(wlevel_o), 8'h4);
        chk("refill_ovf",  8'(wovf_o),   8'h1);

        // Catch the reader up (wbin=5) before streaming.
        bptr = 3'd5;
        rptr_sync2_wrclk_i = gray(bptr);
        step();
        chk("catchup_lvl",  8'(wlevel_o), 8'h0);
        chk("catchup_full", 8'(wfull_o),  8'h0);

        // Wrap stream: 20 writes, each followed by a matching read advance.
        wrap_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev_g = wptr_g_o;
            winc_i = 1'b1;
            step();
            winc_i = 1'b0;
            bptr = bptr + 3'd1;
            diff = prev_g ^ wptr_g_o;
            if (prev_g == 3'b100 && wptr_g_o == 3'b000) wrap_seen = 1'b1;
            chk("wrap_g",    8'(wptr_g_o), 8'(gray(bptr)));
            chk("wrap_1bit", 8'($countones(diff)), 8'h1);
            chk("wrap_lvl1", 8'(wlevel_o), 8'h1);
            chk("wrap_full", 8'(wfull_o),  8'h0);
            rptr_sync2_wrclk_i = gray(bptr);
            step();
            chk("wrap_lvl0", 8'(wlevel_o), 8'h0);
        end
        chk("wrap_seen", 8'(wrap_seen), 8'h1);
        chk("wrap_ovf",  8'(wovf_o),    8'h1);

        // Almost-full sequence from a clean reset.
        wrst_n_i = 1'b0;
        rptr_sync2_wrclk_i = 3'b000;
        step();
        wrst_n_i = 1'b1;
        step();
        winc_i = 1'b1;
        step(); step();
        winc_i = 1'b0;
        chk("af_lvl2", 8'(wlevel_o), 8'h2);
`ifdef WPTR_FULL_AFULL_EN
        chk("af_at2", 8'(walmost_full_o), 8'h0);
`endif
        winc_i = 1'b1;
        step();
        winc_i = 1'b0;
        chk("af_lvl3", 8'(wlevel_o), 8'h3);
`ifdef WPTR_FULL_AFULL_EN
        chk("af_at3", 8'(walmost_full_o), 8'h1);
`endif
        rptr_sync2_wrclk_i = 3'b001;
        step();
        chk("af_lvl_back2", 8'(wlevel_o), 8'h2);
`ifdef WPTR_FULL_AFULL_EN
        chk("af_fall", 8'(walmost_full_o), 8'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
